// File: rtl/ldmstm_sequencer_pkg.sv
// Shared types for the LDM/STM block-transfer sequencer: FSM states,
// {P,U} addressing-mode encoding, default stride and a lowest-set-bit helper.
package ldmstm_sequencer_pkg;

  localparam int DEFAULT_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Encoding is {P,U}: P selects pre-index, U selects upward addressing.
  typedef enum logic [1:0] {
    MODE_DA = 2'b00,
    MODE_IA = 2'b01,
    MODE_DB = 2'b10,
    MODE_IB = 2'b11
  } mode_t;

  function automatic logic [3:0] lowest_index(input logic [15:0] list);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (list[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ldmstm_sequencer_countones.sv
// Population count of the 16-bit register list (0..16).
module countones (
  input  logic [15:0] value,
  output logic [4:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < 16; i++) begin
      count = count + {4'b0, value[i]};
    end
  end

endmodule

// File: rtl/ldmstm_sequencer.sv
// LDM/STM sequencer: expands a register list into one transfer per cycle.
// Optional base writeback is built only when LDMSTM_WRITEBACK_EN is defined.
module ldmstm_sequencer
  import ldmstm_sequencer_pkg::*;
#(
  parameter int AW         = 32,
  parameter int WORD_BYTES = DEFAULT_WORD_BYTES
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [15:0]   reglist,
  input  logic [AW-1:0] rn_base,
  input  logic          p_bit,
  input  logic          u_bit,
  input  logic          l_bit,
  input  logic          stall,
  output logic          busy,
  output logic          uop_valid,
  output logic [3:0]    uop_reg,
  output logic [AW-1:0] uop_addr,
  output logic          uop_load,
  output logic          uop_last,
  output logic          done,
  output logic          wb_valid,
  output logic [AW-1:0] wb_value
);

  state_t        state, state_next;
  mode_t         mode;
  logic [15:0]   work;
  logic [AW-1:0] addr;
  logic          load_q;
  logic [4:0]    count;
  logic [AW-1:0] stride;
  logic [AW-1:0] span;
  logic [AW-1:0] start_addr;
  logic          accept;

  countones u_countones (
    .value (reglist),
    .count (count)
  );

  assign stride = AW'(WORD_BYTES);
  assign span   = AW'(count) * stride;
  assign mode   = mode_t'({p_bit, u_bit});
  assign accept = (state == IDLE) && start && !stall;

  // Lowest address of the block; transfers always walk upward from here.
  always_comb begin
    start_addr = rn_base;
    case (mode)
      MODE_IA: start_addr = rn_base;
      MODE_IB: start_addr = rn_base + stride;
      MODE_DA: start_addr = rn_base - span + stride;
      MODE_DB: start_addr = rn_base - span;
      default: start_addr = rn_base;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else if (!stall) state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (count == 5'd0) ? FINISH : ISSUE;
      ISSUE:   if (uop_last) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Each accepted transfer retires the lowest set bit of the working list.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work   <= '0;
      addr   <= '0;
      load_q <= 1'b0;
    end else if (accept) begin
      work   <= reglist;
      addr   <= start_addr;
      load_q <= l_bit;
    end else if (!stall && state == ISSUE) begin
      work <= work & (work - 16'd1);
      addr <= addr + stride;
    end
  end

  assign busy      = (state != IDLE);
  assign uop_valid = (state == ISSUE);
  assign uop_reg   = lowest_index(work);
  assign uop_addr  = addr;
  assign uop_load  = load_q;
  assign uop_last  = (work != '0) && ((work & (work - 16'd1)) == '0);
  assign done      = (state == FINISH);

`ifdef LDMSTM_WRITEBACK_EN
  logic [AW-1:0] wb_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wb_q <= '0;
    else if (accept) wb_q <= u_bit ? (rn_base + span) : (rn_base - span);
  end

  assign wb_valid = done;
  assign wb_value = wb_q;
`else
  assign wb_valid = 1'b0;
  assign wb_value = '0;
`endif

endmodule

// File: tb/tb_ldmstm_sequencer.sv
// Self-checking bench for ldmstm_sequencer: queue-based transfer model checked
// every cycle, plus literal expectations for the directed scenarios.
module tb_ldmstm_sequencer;

  typedef struct {
    logic [3:0]  r;
    logic [31:0] a;
  } xfer_t;

  typedef struct {
    logic [3:0]  r;
    logic [31:0] a;
    logic        last;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] reglist = '0;
  logic [31:0] rn_base = '0;
  logic        p_bit = 1'b0;
  logic        u_bit = 1'b0;
  logic        l_bit = 1'b0;
  logic        stall = 1'b0;
  logic        busy;
  logic        uop_valid;
  logic [3:0]  uop_reg;
  logic [31:0] uop_addr;
  logic        uop_load;
  logic        uop_last;
  logic        done;
  logic        wb_valid;
  logic [31:0] wb_value;

  int checks = 0;
  int errors = 0;

  xfer_t       m_q[$];
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_load = 1'b0;
  logic [31:0] m_wb = '0;
  obs_t        obs_q[$];

  ldmstm_sequencer #(.AW(32), .WORD_BYTES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .reglist   (reglist),
    .rn_base   (rn_base),
    .p_bit     (p_bit),
    .u_bit     (u_bit),
    .l_bit     (l_bit),
    .stall     (stall),
    .busy      (busy),
    .uop_valid (uop_valid),
    .uop_reg   (uop_reg),
    .uop_addr  (uop_addr),
    .uop_load  (uop_load),
    .uop_last  (uop_last),
    .done      (done),
    .wb_valid  (wb_valid),
    .wb_value  (wb_value)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expand an accepted request into the ordered transfer list it must produce.
  task automatic model_accept();
    int n;
    int k;
    logic [31:0] lo;
    xfer_t x;
    n  = $countones(reglist);
    lo = u_bit ? (p_bit ? rn_base + 32'd4 : rn_base)
               : (p_bit ? rn_base - 32'(4 * n) : rn_base - 32'(4 * n) + 32'd4);
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (reglist[i]) begin
        x.r = 4'(i);
        x.a = lo + 32'(4 * k);
        m_q.push_back(x);
        k++;
      end
    end
    m_wb   = u_bit ? rn_base + 32'(4 * n) : rn_base - 32'(4 * n);
    m_load = l_bit;
    m_busy = 1'b1;
    m_done = (n == 0);
  endtask

  initial begin
    xfer_t tmp;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_q.delete();
        m_busy = 1'b0;
        m_done = 1'b0;
        m_load = 1'b0;
        m_wb   = '0;
      end else if (!stall) begin
        if (m_done) begin
          m_done = 1'b0;
          m_busy = 1'b0;
        end else if (m_q.size() > 0) begin
          tmp = m_q.pop_front();
          if (m_q.size() == 0) m_done = 1'b1;
        end else if (!m_busy && start) begin
          model_accept();
        end
      end
    end
  end

  initial begin
    obs_t o;
    forever begin
      @(negedge clk);
      check_output("busy", 32'(busy), 32'(m_busy));
      check_output("uop_valid", 32'(uop_valid), 32'(m_q.size() > 0));
      check_output("uop_last", 32'(uop_last), 32'(m_q.size() == 1));
      check_output("done", 32'(done), 32'(m_done));
`ifdef LDMSTM_WRITEBACK_EN
      check_output("wb_valid", 32'(wb_valid), 32'(m_done));
      if (m_done) check_output("wb_value", wb_value, m_wb);
`else
      check_output("wb_valid", 32'(wb_valid), 32'd0);
      check_output("wb_value", wb_value, 32'd0);
`endif
      if (m_q.size() > 0) begin
        check_output("uop_reg", 32'(uop_reg), 32'(m_q[0].r));
        check_output("uop_addr", uop_addr, m_q[0].a);
        check_output("uop_load", 32'(uop_load), 32'(m_load));
      end
      if (uop_valid && !stall && !reset) begin
        o.r = uop_reg;
        o.a = uop_addr;
        o.last = uop_last;
        obs_q.push_back(o);
      end
    end
  end

  task automatic check_xfer(input string name, input int idx, input logic [3:0] r,
                            input logic [31:0] a, input logic last);
    if (idx >= obs_q.size()) begin
      check_output({name, " missing"}, 32'(obs_q.size()), 32'(idx + 1));
    end else begin
      check_output({name, " reg"}, 32'(obs_q[idx].r), 32'(r));
      check_output({name, " addr"}, obs_q[idx].a, a);
      check_output({name, " last"}, 32'(obs_q[idx].last), 32'(last));
    end
  endtask

  // Launch one block transfer and wait (bounded) for done; checks latency and writeback.
  task automatic apply_stimulus(input string name, input logic [15:0] rl, input logic [31:0] rn,
                                input logic p, input logic u, input logic l, input logic hold_start,
                                input int stall_at, input int exp_lat, input logic [31:0] exp_wb);
    int k;
    logic done_seen;
    logic [3:0] h_reg;
    logic [31:0] h_addr;
    logic h_valid, h_last;
    logic got_wb_valid;
    logic [31:0] got_wb;
    obs_q.delete();
    reglist = rl;
    rn_base = rn;
    p_bit = p;
    u_bit = u;
    l_bit = l;
    start = 1'b1;
    step();
    if (!hold_start) start = 1'b0;
    reglist = ~rl;
    rn_base = ~rn;
    l_bit = ~l;
    k = 1;
    done_seen = 1'b0;
    got_wb_valid = 1'b0;
    got_wb = '0;
    while (k <= 40 && !done_seen) begin
      if (done) begin
        done_seen = 1'b1;
        got_wb_valid = wb_valid;
        got_wb = wb_value;
      end else begin
        if (k == stall_at) begin
          h_reg = uop_reg;
          h_addr = uop_addr;
          h_valid = uop_valid;
          h_last = uop_last;
          stall = 1'b1;
          repeat (3) begin
            step();
            k++;
            check_output({name, " hold reg"}, 32'(uop_reg), 32'(h_reg));
            check_output({name, " hold addr"}, uop_addr, h_addr);
            check_output({name, " hold valid"}, 32'(uop_valid), 32'(h_valid));
            check_output({name, " hold last"}, 32'(uop_last), 32'(h_last));
          end
          stall = 1'b0;
        end
        step();
        k++;
      end
    end
    check_output({name, " done seen"}, 32'(done_seen), 32'd1);
    check_output({name, " done latency"}, 32'(k), 32'(exp_lat));
`ifdef LDMSTM_WRITEBACK_EN
    check_output({name, " wb_valid"}, 32'(got_wb_valid), 32'd1);
    check_output({name, " wb_value"}, got_wb, exp_wb);
`else
    check_output({name, " wb_valid"}, 32'(got_wb_valid), 32'd0);
    check_output({name, " wb_value"}, got_wb, 32'd0);
`endif
    start = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_output("rst busy", 32'(busy), 32'd0);
    check_output("rst uop_valid", 32'(uop_valid), 32'd0);
    check_output("rst uop_last", 32'(uop_last), 32'd0);
    check_output("rst done", 32'(done), 32'd0);
    check_output("rst wb_valid", 32'(wb_valid), 32'd0);
    check_output("rst uop_reg", 32'(uop_reg), 32'd0);
    check_output("rst uop_addr", uop_addr, 32'd0);
    check_output("rst uop_load", 32'(uop_load), 32'd0);
    check_output("rst wb_value", wb_value, 32'd0);
    reset = 1'b0;
    step();

    apply_stimulus("IA", 16'h000F, 32'h100, 1'b0, 1'b1, 1'b1, 1'b0, 0, 5, 32'h110);
    check_output("IA count", 32'(obs_q.size()), 32'd4);
    check_xfer("IA x0", 0, 4'd0, 32'h100, 1'b0);
    check_xfer("IA x1", 1, 4'd1, 32'h104, 1'b0);
    check_xfer("IA x2", 2, 4'd2, 32'h108, 1'b0);
    check_xfer("IA x3", 3, 4'd3, 32'h10C, 1'b1);

    apply_stimulus("DB", 16'h8001, 32'h200, 1'b1, 1'b0, 1'b0, 1'b1, 0, 3, 32'h1F8);
    check_output("DB count", 32'(obs_q.size()), 32'd2);
    check_xfer("DB x0", 0, 4'd0, 32'h1F8, 1'b0);
    check_xfer("DB x1", 1, 4'd15, 32'h1FC, 1'b1);
    check_output("DB idle after", 32'(busy), 32'd0);

    apply_stimulus("FULL", 16'hFFFF, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 17, 32'h40);
    check_output("FULL count", 32'(obs_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check_xfer("FULL x", i, 4'(i), 32'(4 * i + 4), i == 15);
    end

    apply_stimulus("EMPTY", 16'h0000, 32'h300, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1, 32'h300);
    check_output("EMPTY count", 32'(obs_q.size()), 32'd0);

    apply_stimulus("WRAP", 16'h0007, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 1'b0, 2, 7, 32'h8);
    check_output("WRAP count", 32'(obs_q.size()), 32'd3);
    check_xfer("WRAP x0", 0, 4'd0, 32'h0, 1'b0);
    check_xfer("WRAP x1", 1, 4'd1, 32'h4, 1'b0);
    check_xfer("WRAP x2", 2, 4'd2, 32'h8, 1'b1);

    reglist = 16'h00FF;
    rn_base = 32'h400;
    p_bit = 1'b0;
    u_bit = 1'b1;
    l_bit = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    check_output("MIDRST pre reg", 32'(uop_reg), 32'd2);
    check_output("MIDRST pre addr", uop_addr, 32'h408);
    reset = 1'b1;
    #1;
    check_output("MIDRST busy", 32'(busy), 32'd0);
    check_output("MIDRST uop_valid", 32'(uop_valid), 32'd0);
    check_output("MIDRST uop_last", 32'(uop_last), 32'd0);
    check_output("MIDRST done", 32'(done), 32'd0);
    check_output("MIDRST wb_valid", 32'(wb_valid), 32'd0);
    check_output("MIDRST uop_reg", 32'(uop_reg), 32'd0);
    check_output("MIDRST uop_addr", uop_addr, 32'd0);
    check_output("MIDRST uop_load", 32'(uop_load), 32'd0);
    check_output("MIDRST wb_value", wb_value, 32'd0);
    step();
    reset = 1'b0;
    repeat (3) begin
      step();
      check_output("MIDRST quiet done", 32'(done), 32'd0);
      check_output("MIDRST quiet busy", 32'(busy), 32'd0);
    end

    apply_stimulus("DA", 16'h0030, 32'h500, 1'b0, 1'b0, 1'b1, 1'b0, 0, 3, 32'h4F8);
    check_output("DA count", 32'(obs_q.size()), 32'd2);
    check_xfer("DA x0", 0, 4'd4, 32'h4FC, 1'b0);
    check_xfer("DA x1", 1, 4'd5, 32'h500, 1'b1);

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ldmstm_sequencer.md
LDMSTM_SEQUENCER -- requirements
Module: ldmstm_sequencer

Interface
REQ-001 Parameter AW, default 32: address/data width in bits.
REQ-002 Parameter WORD_BYTES, default 4: byte stride between consecutive transfers.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to begin a block transfer; sampled only when busy=0.
REQ-006 reglist  input  16  register-list field; bit i set means register i is transferred.
REQ-007 rn_base  input  AW  base register value.
REQ-008 p_bit, u_bit, l_bit  input  1 each  pre-index, up and load flags.
REQ-009 stall  input  1  downstream hold; when 1, all state and outputs freeze.
REQ-010 busy  output  1  sequencer is occupied; start ignored.
REQ-011 uop_valid  output  1  one transfer is presented this cycle.
REQ-012 uop_reg  output  4  register number of the current transfer.
REQ-013 uop_addr  output  AW  word address of the current transfer.
REQ-014 uop_load  output  1  copy of the latched l_bit.
REQ-015 uop_last  output  1  current transfer is the final one.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 wb_valid, wb_value  output  1, AW  base-register writeback strobe and value.

Function
REQ-018 Handshake: start with busy=0 on edge t latches reglist, rn_base, p_bit, u_bit and l_bit; busy=1 from t+1.
REQ-019 FSM states: IDLE, ISSUE, FINISH.
REQ-020 IDLE->ISSUE on start when n>0; IDLE->FINISH on start when n=0.
REQ-021 ISSUE->FINISH after the uop_last transfer is accepted (stall=0).
REQ-022 FINISH->IDLE unconditionally, unless stall=1.
REQ-023 n = popcount(reglist), range 0..16, 5 bits.
REQ-024 Start address: IA (P=0,U=1) = Rn; IB (1,1) = Rn+4; DA (0,0) = Rn-4n+4; DB (1,0) = Rn-4n.
REQ-025 Start-address arithmetic is modulo 2^AW, with the stride equal to WORD_BYTES.
REQ-026 Issue order: registers in ascending number, addresses ascending by WORD_BYTES per transfer.
REQ-027 First uop_valid occurs at cycle t+1; each non-stalled cycle in ISSUE issues exactly one transfer.
REQ-028 The sequencer locates the next register by clearing the lowest set bit of the working copy of the register list.
REQ-029 uop_last=1 exactly when one set bit remains in the working list.
REQ-030 done=1 for one non-stalled cycle in FINISH; uop_valid=0 in IDLE and FINISH.
REQ-031 Empty reglist (n=0): no transfers; done at t+1; writeback value = Rn.
REQ-032 stall=1 in any state holds the FSM, working list, address and all outputs unchanged.
REQ-033 start while busy=1 is ignored and not queued.
REQ-034 start coincident with done: the new start is ignored (busy is still 1).

Reset
REQ-035 Reset forces IDLE with busy=0, uop_valid=0, uop_last=0, done=0 and wb_valid=0.
REQ-036 Reset forces uop_reg=0, uop_addr=0, uop_load=0 and wb_value=0.
REQ-037 Reset asserted mid-operation discards the remaining transfers; no done or writeback is produced.

Configuration
REQ-038 Macro LDMSTM_WRITEBACK_EN defined: wb_valid=1 with done; wb_value = U ? Rn+4n : Rn-4n.
REQ-039 Macro LDMSTM_WRITEBACK_EN undefined: wb_valid and wb_value are constant 0, and no writeback adder is built.

Structure
REQ-040 A shared package holds the FSM state enum, the WORD_BYTES constant and the addressing-mode encoding {P,U}.
REQ-041 The popcount is one instantiated sub-module, countones (16-bit input, 5-bit count); no other sub-modules.

Verification
REQ-042 Scenario IA: reglist=0x000F, Rn=0x100, P=0, U=1 -> regs 0,1,2,3 at 0x100, 0x104, 0x108, 0x10C; uop_last on the fourth transfer; wb_value=0x110.
REQ-043 Scenario DB: reglist=0x8001, Rn=0x200, P=1, U=0 -> r0@0x1F8, r15@0x1FC; wb_value=0x1F8.
REQ-044 Scenario full list: reglist=0xFFFF, IB, Rn=0 -> 16 transfers at 0x4..0x40; done 17 cycles after start; wb_value=0x40.
REQ-045 Scenario empty list: reglist=0 -> no uop_valid; done at t+1; wb_value=Rn.
REQ-046 Scenario stall and wrap: stall=1 for 3 cycles mid-sequence -> identical uop outputs are held; with Rn=0xFFFFFFFC in IB mode the first address is 0x0.
REQ-047 Scenario reset mid-operation: reset asserted mid-sequence -> outputs clear immediately; a following start behaves normally.
